// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stopwatch_pkg                                              |
// | Description : Shared types and constants for the stopwatch control       |
// |               front-end (state encoding, default debounce length,        |
// |               counter sizing helper).                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE   = 2'd0,
        SW_RUN    = 2'd1,
        SW_PAUSED = 2'd2,
        SW_LAP    = 2'd3
    } sw_state_t;

    // 10 ms of stable input at 100 MHz.
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

    // Width of a counter that must hold values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : btn_debounce                                               |
// | Description : Synchroniser + debouncer + press-edge detector for one     |
// |               raw asynchronous push-button.                              |
// | Ports       : clk100MHz  in  main clock                                  |
// |               rst_n      in  async active-low reset                      |
// |               btn_raw    in  raw button, asynchronous, active high       |
// |               btn_level  out debounced button level                      |
// |               btn_press  out one-cycle pulse on debounced 0->1 edge      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk100MHz,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int                 c_CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_press;
    logic                   w_synced;

    // Plain shift-register synchroniser; the oldest stage is the safe sample.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // The counter only runs while the synced input disagrees with the
    // accepted level, so any return to the old level restarts the window.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_synced == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_level <= w_synced;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Rising-edge detector on the debounced level; release is ignored.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                             |
// | Description : Button front-end and run/pause/clear control FSM for the   |
// |               stopwatch. Produces registered, quasi-static level outputs |
// |               that the slow 100 Hz counter domain can sample directly.   |
// | Macro       : STOPWATCH_LAP_EN - builds the lap debouncer and LAP state; |
// |               when undefined lap_btn is ignored and disp_hold is 0.      |
// | Ports       : clk100MHz  in  main clock                                  |
// |               rst_n      in  async active-low reset                      |
// |               start_btn  in  raw start button                            |
// |               stop_btn   in  raw stop/clear button                       |
// |               lap_btn    in  raw lap button                              |
// |               cnt_en     out counter count enable                        |
// |               cnt_clr    out counter hold-at-zero                        |
// |               disp_hold  out freeze display value                        |
// |               run_led    out high while time is advancing                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk100MHz,
    input  logic rst_n,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic lap_btn,
    output logic cnt_en,
    output logic cnt_clr,
    output logic disp_hold,
    output logic run_led
);

    localparam logic [1:0] c_ST_IDLE   = SW_IDLE;
    localparam logic [1:0] c_ST_RUN    = SW_RUN;
    localparam logic [1:0] c_ST_PAUSED = SW_PAUSED;
`ifdef STOPWATCH_LAP_EN
    localparam logic [1:0] c_ST_LAP    = SW_LAP;
`endif

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_start_press;
    logic       w_stop_press;
    logic       w_start_level_unused;
    logic       w_stop_level_unused;
    logic       r_cnt_en;
    logic       r_cnt_clr;
    logic       w_cnt_en_next;
    logic       w_cnt_clr_next;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .btn_raw   (start_btn),
        .btn_level (w_start_level_unused),
        .btn_press (w_start_press)
    );

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_stop_db (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .btn_raw   (stop_btn),
        .btn_level (w_stop_level_unused),
        .btn_press (w_stop_press)
    );

`ifdef STOPWATCH_LAP_EN
    logic w_lap_press;
    logic w_lap_level_unused;
    logic r_disp_hold;
    logic w_disp_hold_next;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lap_db (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .btn_raw   (lap_btn),
        .btn_level (w_lap_level_unused),
        .btn_press (w_lap_press)
    );
`else
    logic w_lap_btn_unused;
    assign w_lap_btn_unused = lap_btn;
`endif

    // Event priority is stop > start > lap: a lower-priority press is only
    // considered when no higher-priority press is present, even if the
    // higher one has no effect in the current state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_stop_press && w_start_press) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_stop_press) begin
                    w_state_next = c_ST_PAUSED;
`ifdef STOPWATCH_LAP_EN
                end else if (!w_start_press && w_lap_press) begin
                    w_state_next = c_ST_LAP;
`endif
                end
            end
            c_ST_PAUSED: begin
                if (w_stop_press) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_start_press) begin
                    w_state_next = c_ST_RUN;
                end
            end
`ifdef STOPWATCH_LAP_EN
            c_ST_LAP: begin
                if (w_stop_press) begin
                    w_state_next = c_ST_PAUSED;
                end else if (!w_start_press && w_lap_press) begin
                    w_state_next = c_ST_RUN;
                end
            end
`endif
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs are decoded from the next state and registered, so they move
    // together with the state and are glitch-free levels for the slow domain.
    always_comb begin
        w_cnt_clr_next = (w_state_next == c_ST_IDLE);
`ifdef STOPWATCH_LAP_EN
        w_cnt_en_next    = (w_state_next == c_ST_RUN) || (w_state_next == c_ST_LAP);
        w_disp_hold_next = (w_state_next == c_ST_LAP);
`else
        w_cnt_en_next    = (w_state_next == c_ST_RUN);
`endif
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b1;
        end else begin
            r_cnt_en  <= w_cnt_en_next;
            r_cnt_clr <= w_cnt_clr_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_hold <= 1'b0;
        end else begin
            r_disp_hold <= w_disp_hold_next;
        end
    end

    assign disp_hold = r_disp_hold;
`else
    assign disp_hold = 1'b0;
`endif

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    // Time advances exactly when the counter is enabled.
    assign run_led = r_cnt_en;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                          |
// | Description : Self-checking bench for stopwatch_ctrl with a short        |
// |               debounce window. Expected output vectors come from a       |
// |               small state model and are queued at stimulus time.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stopwatch_ctrl;

    localparam int c_DB = 4;
    localparam int c_SS = 2;
    // Edges from the first sampling edge of a raw step to the output change.
    localparam int c_OUT_EDGES = c_SS + c_DB + 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit c_LAP_EN = 1'b1;
`else
    localparam bit c_LAP_EN = 1'b0;
`endif

    // Model state encoding and output vectors {cnt_en, cnt_clr, disp_hold, run_led}.
    localparam int         c_M_IDLE   = 0;
    localparam int         c_M_RUN    = 1;
    localparam int         c_M_PAUSED = 2;
    localparam int         c_M_LAP    = 3;
    localparam logic [3:0] c_O_IDLE   = 4'b0100;
    localparam logic [3:0] c_O_RUN    = 4'b1001;
    localparam logic [3:0] c_O_PAUSED = 4'b0000;
    localparam logic [3:0] c_O_LAP    = 4'b1011;

    logic clk100MHz = 1'b0;
    logic rst_n     = 1'b0;
    logic start_btn = 1'b0;
    logic stop_btn  = 1'b0;
    logic lap_btn   = 1'b0;
    logic cnt_en;
    logic cnt_clr;
    logic disp_hold;
    logic run_led;

    int         errors = 0;
    int         checks = 0;
    int         m_state = c_M_IDLE;
    int         start_pulses = 0;
    int         stop_pulses  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (c_DB),
        .SYNC_STAGES     (c_SS)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .lap_btn   (lap_btn),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .disp_hold (disp_hold),
        .run_led   (run_led)
    );

    always #5 clk100MHz = ~clk100MHz;

    always @(negedge clk100MHz) begin
        if (dut.w_start_press === 1'b1) start_pulses++;
        if (dut.w_stop_press  === 1'b1) stop_pulses++;
    end

    function automatic logic [3:0] outs(input int s);
        case (s)
            c_M_RUN:    return c_O_RUN;
            c_M_PAUSED: return c_O_PAUSED;
            c_M_LAP:    return c_O_LAP;
            default:    return c_O_IDLE;
        endcase
    endfunction

    function automatic int model_next(input int s, input bit st, input bit sp, input bit lp);
        if (sp) begin
            if (s == c_M_RUN || s == c_M_LAP) return c_M_PAUSED;
            if (s == c_M_PAUSED)              return c_M_IDLE;
            return s;
        end
        if (st) begin
            if (s == c_M_IDLE || s == c_M_PAUSED) return c_M_RUN;
            return s;
        end
        if (lp && c_LAP_EN) begin
            if (s == c_M_RUN) return c_M_LAP;
            if (s == c_M_LAP) return c_M_RUN;
        end
        return s;
    endfunction

    function automatic logic [3:0] obs();
        return {cnt_en, cnt_clr, disp_hold, run_led};
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk100MHz);
        #1;
    endtask

    // Drive a clean press, queue expectations for just-before-change,
    // just-after-change and after-release, and queue the matching samples.
    task automatic press(input bit st, input bit sp, input bit lp);
        int nxt;
        nxt = model_next(m_state, st, sp, lp);
        exp_q.push_back(outs(m_state));
        exp_q.push_back(outs(nxt));
        exp_q.push_back(outs(nxt));
        start_btn = st;
        stop_btn  = sp;
        lap_btn   = lp;
        wait_edges(c_OUT_EDGES - 1);
        obs_q.push_back(obs());
        wait_edges(1);
        obs_q.push_back(obs());
        wait_edges(2);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        lap_btn   = 1'b0;
        wait_edges(c_OUT_EDGES + 2);
        obs_q.push_back(obs());
        m_state = nxt;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] o;
        int p0;
        wait_edges(2);
        exp_q.push_back(c_O_IDLE);
        obs_q.push_back(obs());
        rst_n = 1'b1;
        wait_edges(3);
        exp_q.push_back(c_O_IDLE);
        obs_q.push_back(obs());
        press(1'b1, 1'b0, 1'b0);
        // Assert reset while a stop press is half-way through debouncing.
        p0 = stop_pulses;
        stop_btn = 1'b1;
        wait_edges(4);
        rst_n = 1'b0;
        #2;
        exp_q.push_back(c_O_IDLE);
        obs_q.push_back(obs());
        wait_edges(2);
        stop_btn = 1'b0;
        rst_n    = 1'b1;
        m_state  = c_M_IDLE;
        wait_edges(12);
        exp_q.push_back(c_O_IDLE);
        obs_q.push_back(obs());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL reset: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset: outputs got %b expected %b", o, e);
                end
            end
        end
        checks++;
        if (stop_pulses - p0 != 0) begin
            errors++;
            $display("FAIL reset_pulse: stop pulses got %0d expected 0", stop_pulses - p0);
        end
    endtask

    task automatic test_start_latency();
        logic [3:0] e;
        logic [3:0] o;
        logic       pulse_seen [3];
        int         p0;
        p0 = start_pulses;
        exp_q.push_back(c_O_IDLE);
        exp_q.push_back(c_O_IDLE);
        exp_q.push_back(c_O_RUN);
        start_btn = 1'b1;
        wait_edges(c_OUT_EDGES - 2);
        pulse_seen[0] = dut.w_start_press;
        wait_edges(1);
        pulse_seen[1] = dut.w_start_press;
        obs_q.push_back(obs());
        obs_q.push_back(obs());
        wait_edges(1);
        pulse_seen[2] = dut.w_start_press;
        obs_q.push_back(obs());
        wait_edges(20 - c_OUT_EDGES);
        start_btn = 1'b0;
        wait_edges(c_OUT_EDGES + 2);
        m_state = c_M_RUN;
        exp_q.push_back(c_O_RUN);
        obs_q.push_back(obs());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL start_latency: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL start_latency: outputs got %b expected %b", o, e);
                end
            end
        end
        checks++;
        if (pulse_seen[0] !== 1'b0 || pulse_seen[1] !== 1'b1 || pulse_seen[2] !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse_timing: pulse samples got %b%b%b expected 010",
                     pulse_seen[0], pulse_seen[1], pulse_seen[2]);
        end
        checks++;
        if (start_pulses - p0 != 1) begin
            errors++;
            $display("FAIL start_pulse_count: got %0d expected 1", start_pulses - p0);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] e;
        logic [3:0] o;
        int p0;
        int p1;
        p0 = stop_pulses;
        exp_q.push_back(c_O_RUN);
        exp_q.push_back(c_O_PAUSED);
        stop_btn = 1'b1;
        wait_edges(2);
        stop_btn = 1'b0;
        wait_edges(2);
        stop_btn = 1'b1;
        wait_edges(c_OUT_EDGES - 1);
        obs_q.push_back(obs());
        wait_edges(1);
        obs_q.push_back(obs());
        wait_edges(10 - c_OUT_EDGES);
        stop_btn = 1'b0;
        wait_edges(c_OUT_EDGES + 2);
        m_state = c_M_PAUSED;
        p1 = stop_pulses;
        // Three-cycle glitch must be absorbed.
        exp_q.push_back(c_O_PAUSED);
        stop_btn = 1'b1;
        wait_edges(3);
        stop_btn = 1'b0;
        wait_edges(12);
        obs_q.push_back(obs());
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bounce: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bounce: outputs got %b expected %b", o, e);
                end
            end
        end
        checks++;
        if (p1 - p0 != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", p1 - p0);
        end
        checks++;
        if (stop_pulses - p1 != 0) begin
            errors++;
            $display("FAIL glitch_pulse_count: got %0d expected 0", stop_pulses - p1);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] e;
        logic [3:0] o;
        press(1'b0, 1'b1, 1'b0);   // PAUSED -> IDLE
        press(1'b1, 1'b0, 1'b0);   // IDLE -> RUN
        press(1'b0, 1'b1, 1'b0);   // RUN -> PAUSED
        press(1'b1, 1'b0, 1'b0);   // PAUSED -> RUN
        press(1'b0, 1'b1, 1'b0);   // RUN -> PAUSED
        press(1'b0, 1'b1, 1'b0);   // PAUSED -> IDLE
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL sequence: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL sequence: outputs got %b expected %b", o, e);
                end
            end
        end
        checks++;
        if (cnt_clr !== 1'b1) begin
            errors++;
            $display("FAIL sequence_clr: cnt_clr got %b expected 1", cnt_clr);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e;
        logic [3:0] o;
        press(1'b1, 1'b0, 1'b0);   // IDLE -> RUN
        press(1'b1, 1'b1, 1'b0);   // stop wins: RUN -> PAUSED
        press(1'b0, 1'b1, 1'b0);   // PAUSED -> IDLE
        press(1'b1, 1'b1, 1'b0);   // stop wins, no effect in IDLE
        press(1'b1, 1'b0, 1'b1);   // start wins over lap: IDLE -> RUN
        press(1'b1, 1'b0, 1'b1);   // start wins, lap ignored in RUN
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL simultaneous: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL simultaneous: outputs got %b expected %b", o, e);
                end
            end
        end
    endtask

    task automatic test_lap();
        logic [3:0] e;
        logic [3:0] o;
        press(1'b0, 1'b0, 1'b1);   // RUN -> LAP (or no change without lap)
        press(1'b0, 1'b0, 1'b1);   // LAP -> RUN
        press(1'b0, 1'b0, 1'b1);   // RUN -> LAP
        press(1'b1, 1'b0, 1'b0);   // start ignored in LAP
        press(1'b0, 1'b1, 1'b0);   // LAP -> PAUSED, hold released
        press(1'b0, 1'b0, 1'b1);   // lap ignored in PAUSED
        press(1'b0, 1'b1, 1'b0);   // PAUSED -> IDLE
        press(1'b0, 1'b0, 1'b1);   // lap ignored in IDLE
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL lap: no observation for expected %b", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL lap: outputs got %b expected %b", o, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_bounce();
        test_sequence();
        test_simultaneous();
        test_lap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
